// File: rtl/fsm_ctrl.sv
// Packet-framing monitor: follows a head/data/tail beat stream qualified by valid.
// Build option FSM_ERR_CHECK_EN enables err pulses and head-restart handling.
//
// state | meaning
// IDLE  | between packets, waiting for a head beat
// HEAD  | head beat taken, packet open
// DATA  | body beats being taken
// TAIL  | tail beat just taken, packet closed and counted

module fsm_ctrl #(
  parameter int LEN_W = 8,
  parameter int CNT_W = 16
) (
  input  logic             clock,
  input  logic             reset,
  input  logic             head,
  input  logic             tail,
  input  logic             valid,
  output logic [1:0]       state,
  output logic             busy,
  output logic             sop,
  output logic             eop,
  output logic [LEN_W-1:0] pkt_len,
  output logic [CNT_W-1:0] pkt_cnt,
  output logic             err
);

  typedef enum logic [1:0] {
    IDLE = 2'b00,
    HEAD = 2'b01,
    DATA = 2'b10,
    TAIL = 2'b11
  } state_t;

`ifdef FSM_ERR_CHECK_EN
  localparam bit ERR_CHK = 1'b1;
`else
  localparam bit ERR_CHK = 1'b0;
`endif

  localparam logic [LEN_W-1:0] LEN_MAX = '1;
  localparam logic [LEN_W-1:0] LEN_ONE = LEN_W'(1);
  localparam logic [CNT_W-1:0] CNT_ONE = CNT_W'(1);

  state_t           st;
  logic [LEN_W-1:0] len_run;
  logic [LEN_W-1:0] len_inc;

  // Running length sticks at all-ones rather than wrapping on very long packets.
  assign len_inc = (len_run == LEN_MAX) ? len_run : len_run + LEN_ONE;
  assign state   = st;

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      st      <= IDLE;
      busy    <= 1'b0;
      sop     <= 1'b0;
      eop     <= 1'b0;
      err     <= 1'b0;
      len_run <= '0;
      pkt_len <= '0;
      pkt_cnt <= '0;
    end else begin
      sop <= 1'b0;
      eop <= 1'b0;
      err <= 1'b0;
      case (st)
        IDLE: begin
          if (valid && head) begin
            len_run <= LEN_ONE;
            if (tail) begin
              st      <= TAIL;
              busy    <= 1'b0;
              eop     <= 1'b1;
              pkt_len <= LEN_ONE;
              pkt_cnt <= pkt_cnt + CNT_ONE;
            end else begin
              st   <= HEAD;
              busy <= 1'b1;
              sop  <= 1'b1;
            end
          end else if (valid && tail && ERR_CHK) begin
            err <= 1'b1;
          end
        end

        HEAD, DATA: begin
          if (valid) begin
            // Tail wins over a coincident head so the open packet is always closed.
            if (tail) begin
              st      <= TAIL;
              busy    <= 1'b0;
              eop     <= 1'b1;
              len_run <= len_inc;
              pkt_len <= len_inc;
              pkt_cnt <= pkt_cnt + CNT_ONE;
            end else if (head && ERR_CHK) begin
              st      <= HEAD;
              busy    <= 1'b1;
              sop     <= 1'b1;
              err     <= 1'b1;
              len_run <= LEN_ONE;
            end else begin
              st      <= DATA;
              busy    <= 1'b1;
              len_run <= len_inc;
            end
          end
        end

        TAIL: begin
          if (valid && head) begin
            len_run <= LEN_ONE;
            if (tail) begin
              st      <= TAIL;
              busy    <= 1'b0;
              eop     <= 1'b1;
              pkt_len <= LEN_ONE;
              pkt_cnt <= pkt_cnt + CNT_ONE;
            end else begin
              st   <= HEAD;
              busy <= 1'b1;
              sop  <= 1'b1;
            end
          end else begin
            st   <= IDLE;
            busy <= 1'b0;
            if (valid && tail && ERR_CHK) begin
              err <= 1'b1;
            end
          end
        end

        default: begin
          st   <= IDLE;
          busy <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_fsm_ctrl.sv
// Directed bench for fsm_ctrl; expectations follow whichever FSM_ERR_CHECK_EN build is compiled.
module tb_fsm_ctrl;

  logic        clock;
  logic        reset;
  logic        head;
  logic        tail;
  logic        valid;
  logic [1:0]  state;
  logic        busy;
  logic        sop;
  logic        eop;
  logic [7:0]  pkt_len;
  logic [15:0] pkt_cnt;
  logic        err;

  int checks;
  int errors;

  fsm_ctrl #(.LEN_W(8), .CNT_W(16)) dut (
    .clock   (clock),
    .reset   (reset),
    .head    (head),
    .tail    (tail),
    .valid   (valid),
    .state   (state),
    .busy    (busy),
    .sop     (sop),
    .eop     (eop),
    .pkt_len (pkt_len),
    .pkt_cnt (pkt_cnt),
    .err     (err)
  );

  initial clock = 1'b0;
  always #5 clock = ~clock;

  // Observed outputs packed as {state, busy, sop, eop, err, pkt_len, pkt_cnt}.
  logic [29:0] obs;
  assign obs = {state, busy, sop, eop, err, pkt_len, pkt_cnt};

  function automatic logic [29:0] ev(input logic [1:0] s, input logic b, input logic so,
                                     input logic eo, input logic er, input logic [7:0] l,
                                     input logic [15:0] c);
    return {s, b, so, eo, er, l, c};
  endfunction

`ifdef FSM_ERR_CHECK_EN
  localparam bit ERR_ON = 1'b1;
`else
  localparam bit ERR_ON = 1'b0;
`endif

  // Apply one cycle of inputs and land 1 time unit after the sampling edge.
  task automatic step(input logic h, input logic t, input logic v);
    head  = h;
    tail  = t;
    valid = v;
    @(posedge clock);
    #1;
  endtask

  task automatic test_reset;
    reset = 1'b1;
    head = 0; tail = 0; valid = 0;
    for (int i = 0; i < 5; i++) begin
      @(posedge clock);
      #1;
      checks++;
      if (obs !== ev(2'b00, 0, 0, 0, 0, 8'd0, 16'd0)) begin
        errors++;
        $display("FAIL reset_hold[%0d]: got %h want %h", i, obs, ev(2'b00, 0, 0, 0, 0, 8'd0, 16'd0));
      end
    end
    reset = 1'b0;
    for (int i = 0; i < 2; i++) begin
      step(0, 0, 0);
      checks++;
      if (obs !== ev(2'b00, 0, 0, 0, 0, 8'd0, 16'd0)) begin
        errors++;
        $display("FAIL reset_release[%0d]: got %h want %h", i, obs, ev(2'b00, 0, 0, 0, 0, 8'd0, 16'd0));
      end
    end
  endtask

  task automatic test_basic_packet;
    step(1, 0, 1);
    checks++;
    if (obs !== ev(2'b01, 1, 1, 0, 0, 8'd0, 16'd0)) begin
      errors++; $display("FAIL basic_head: got %h want %h", obs, ev(2'b01, 1, 1, 0, 0, 8'd0, 16'd0));
    end
    for (int i = 0; i < 3; i++) begin
      step(0, 0, 1);
      checks++;
      if (obs !== ev(2'b10, 1, 0, 0, 0, 8'd0, 16'd0)) begin
        errors++; $display("FAIL basic_data[%0d]: got %h want %h", i, obs, ev(2'b10, 1, 0, 0, 0, 8'd0, 16'd0));
      end
    end
    step(0, 1, 1);
    checks++;
    if (obs !== ev(2'b11, 0, 0, 1, 0, 8'd5, 16'd1)) begin
      errors++; $display("FAIL basic_tail: got %h want %h", obs, ev(2'b11, 0, 0, 1, 0, 8'd5, 16'd1));
    end
    step(0, 0, 0);
    checks++;
    if (obs !== ev(2'b00, 0, 0, 0, 0, 8'd5, 16'd1)) begin
      errors++; $display("FAIL basic_idle: got %h want %h", obs, ev(2'b00, 0, 0, 0, 0, 8'd5, 16'd1));
    end
  endtask

  task automatic test_stall;
    step(1, 0, 1);
    step(0, 0, 1);
    // Strobes raised while valid is low must be ignored.
    for (int i = 0; i < 2; i++) begin
      step(1, 1, 0);
      checks++;
      if (obs !== ev(2'b10, 1, 0, 0, 0, 8'd5, 16'd1)) begin
        errors++; $display("FAIL stall_hold[%0d]: got %h want %h", i, obs, ev(2'b10, 1, 0, 0, 0, 8'd5, 16'd1));
      end
    end
    step(0, 0, 1);
    step(0, 0, 1);
    step(0, 1, 1);
    checks++;
    if (obs !== ev(2'b11, 0, 0, 1, 0, 8'd5, 16'd2)) begin
      errors++; $display("FAIL stall_tail: got %h want %h", obs, ev(2'b11, 0, 0, 1, 0, 8'd5, 16'd2));
    end
    step(0, 0, 0);
  endtask

  task automatic test_single_beat;
    step(1, 1, 1);
    checks++;
    if (obs !== ev(2'b11, 0, 0, 1, 0, 8'd1, 16'd3)) begin
      errors++; $display("FAIL single_tail: got %h want %h", obs, ev(2'b11, 0, 0, 1, 0, 8'd1, 16'd3));
    end
    step(0, 0, 0);
    checks++;
    if (obs !== ev(2'b00, 0, 0, 0, 0, 8'd1, 16'd3)) begin
      errors++; $display("FAIL single_idle: got %h want %h", obs, ev(2'b00, 0, 0, 0, 0, 8'd1, 16'd3));
    end
  endtask

  task automatic test_back_to_back;
    step(1, 0, 1);
    step(0, 1, 1);
    checks++;
    if (obs !== ev(2'b11, 0, 0, 1, 0, 8'd2, 16'd4)) begin
      errors++; $display("FAIL b2b_tail1: got %h want %h", obs, ev(2'b11, 0, 0, 1, 0, 8'd2, 16'd4));
    end
    step(1, 0, 1);
    checks++;
    if (obs !== ev(2'b01, 1, 1, 0, 0, 8'd2, 16'd4)) begin
      errors++; $display("FAIL b2b_head2: got %h want %h", obs, ev(2'b01, 1, 1, 0, 0, 8'd2, 16'd4));
    end
    step(0, 1, 1);
    checks++;
    if (obs !== ev(2'b11, 0, 0, 1, 0, 8'd2, 16'd5)) begin
      errors++; $display("FAIL b2b_tail2: got %h want %h", obs, ev(2'b11, 0, 0, 1, 0, 8'd2, 16'd5));
    end
    step(1, 1, 1);
    checks++;
    if (obs !== ev(2'b11, 0, 0, 1, 0, 8'd1, 16'd6)) begin
      errors++; $display("FAIL b2b_single: got %h want %h", obs, ev(2'b11, 0, 0, 1, 0, 8'd1, 16'd6));
    end
    step(0, 0, 0);
    checks++;
    if (obs !== ev(2'b00, 0, 0, 0, 0, 8'd1, 16'd6)) begin
      errors++; $display("FAIL b2b_idle: got %h want %h", obs, ev(2'b00, 0, 0, 0, 0, 8'd1, 16'd6));
    end
  endtask

  task automatic test_restart;
    logic [29:0] e_mid;
    logic [29:0] e_end;
    e_mid = ERR_ON ? ev(2'b01, 1, 1, 0, 1, 8'd1, 16'd6) : ev(2'b10, 1, 0, 0, 0, 8'd1, 16'd6);
    e_end = ERR_ON ? ev(2'b11, 0, 0, 1, 0, 8'd2, 16'd7) : ev(2'b11, 0, 0, 1, 0, 8'd4, 16'd7);
    step(1, 0, 1);
    step(0, 0, 1);
    step(1, 0, 1);
    checks++;
    if (obs !== e_mid) begin
      errors++; $display("FAIL restart_head: got %h want %h", obs, e_mid);
    end
    step(0, 0, 0);
    checks++;
    if (err !== 1'b0) begin
      errors++; $display("FAIL restart_err_once: got %b want 0", err);
    end
    step(0, 1, 1);
    checks++;
    if (obs !== e_end) begin
      errors++; $display("FAIL restart_tail: got %h want %h", obs, e_end);
    end
    step(0, 0, 0);
  endtask

  task automatic test_stray_tail;
    logic [7:0] l0;
    l0 = ERR_ON ? 8'd2 : 8'd4;
    step(0, 1, 1);
    checks++;
    if (obs !== ev(2'b00, 0, 0, 0, ERR_ON, l0, 16'd7)) begin
      errors++; $display("FAIL stray_idle: got %h want %h", obs, ev(2'b00, 0, 0, 0, ERR_ON, l0, 16'd7));
    end
    step(1, 0, 1);
    step(0, 1, 1);
    step(0, 1, 1);
    checks++;
    if (obs !== ev(2'b00, 0, 0, 0, ERR_ON, 8'd2, 16'd8)) begin
      errors++; $display("FAIL stray_after_tail: got %h want %h", obs, ev(2'b00, 0, 0, 0, ERR_ON, 8'd2, 16'd8));
    end
    step(0, 0, 0);
  endtask

  task automatic test_saturation;
    step(1, 0, 1);
    for (int i = 0; i < 298; i++) step(0, 0, 1);
    step(0, 1, 1);
    checks++;
    if (obs !== ev(2'b11, 0, 0, 1, 0, 8'd255, 16'd9)) begin
      errors++; $display("FAIL saturate: got %h want %h", obs, ev(2'b11, 0, 0, 1, 0, 8'd255, 16'd9));
    end
    step(0, 0, 0);
  endtask

  task automatic test_reset_mid;
    step(1, 0, 1);
    step(0, 0, 1);
    #1;
    reset = 1'b1;
    #1;
    checks++;
    if (obs !== ev(2'b00, 0, 0, 0, 0, 8'd0, 16'd0)) begin
      errors++; $display("FAIL reset_async: got %h want %h", obs, ev(2'b00, 0, 0, 0, 0, 8'd0, 16'd0));
    end
    @(negedge clock);
    reset = 1'b0;
    step(0, 0, 1);
    checks++;
    if (obs !== ev(2'b00, 0, 0, 0, 0, 8'd0, 16'd0)) begin
      errors++; $display("FAIL reset_from_idle: got %h want %h", obs, ev(2'b00, 0, 0, 0, 0, 8'd0, 16'd0));
    end
    step(1, 1, 1);
    checks++;
    if (obs !== ev(2'b11, 0, 0, 1, 0, 8'd1, 16'd1)) begin
      errors++; $display("FAIL reset_restart_cnt: got %h want %h", obs, ev(2'b11, 0, 0, 1, 0, 8'd1, 16'd1));
    end
  endtask

  initial begin
    checks = 0;
    errors = 0;
    reset = 1'b1;
    head = 0; tail = 0; valid = 0;
    test_reset();
    test_basic_packet();
    test_stall();
    test_single_beat();
    test_back_to_back();
    test_restart();
    test_stray_tail();
    test_saturation();
    test_reset_mid();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/fsm_ctrl.md
# fsm_ctrl

Packet-framing state machine that tracks a head/data/tail beat stream qualified by `valid`. It reports the current framing state, start/end-of-packet pulses, the length of the last completed packet, a count of completed packets, and protocol errors. It sits beside a streaming datapath as a passive monitor/controller: it observes the framing strobes and never back-pressures them.

## Interface
Module name: `fsm_ctrl`. One clock; reset is asynchronous and active-high.

Parameters:
- `LEN_W`, default 8: width of the packet-length counter and the `pkt_len` output.
- `CNT_W`, default 16: width of the completed-packet counter `pkt_cnt`.

Ports:
- `clock`  in  1  rising-edge clock.
- `reset`  in  1  asynchronous active-high reset.
- `head`  in  1  first beat of a packet; meaningful only when `valid`=1.
- `tail`  in  1  last beat of a packet; meaningful only when `valid`=1.
- `valid`  in  1  beat qualifier; when 0, `head` and `tail` are ignored.
- `state`  out  2  current state: IDLE=2'b00, HEAD=2'b01, DATA=2'b10, TAIL=2'b11.
- `busy`  out  1  high while `state` is HEAD or DATA.
- `sop`  out  1  one-cycle pulse on entry to HEAD.
- `eop`  out  1  one-cycle pulse on entry to TAIL.
- `pkt_len`  out  LEN_W  beat count of the last completed packet, including head and tail beats.
- `pkt_cnt`  out  CNT_W  number of completed packets; wraps modulo 2^CNT_W.
- `err`  out  1  one-cycle protocol-error pulse.

## Operation
- A beat is a rising clock edge with `valid`=1. Cycles with `valid`=0 are stalls and hold the state.
- IDLE:
  - `valid&head&~tail` goes to HEAD.
  - `valid&head&tail` goes to TAIL (single-beat packet, length 1).
  - `valid&~head&tail` pulses `err` and stays in IDLE.
  - Anything else stays in IDLE.
- HEAD:
  - `valid&tail` goes to TAIL.
  - `valid&~tail&~head` goes to DATA.
  - `valid&head` is a restart: pulse `err`, re-enter HEAD (`sop` pulses again), and reset the running length to 1.
  - `~valid` holds HEAD.
- DATA:
  - `valid&tail` goes to TAIL.
  - `valid&head` is a restart, handled as in HEAD.
  - `valid` with neither strobe stays in DATA.
  - `~valid` holds DATA.
- TAIL:
  - `valid&head` goes to HEAD (back-to-back packet); if `tail` is also set, go to TAIL (single-beat packet).
  - Anything else goes to IDLE.
  - A tail without head here pulses `err` and goes to IDLE.
- Running length counter:
  - Loads 1 on a head beat.
  - Increments on every other beat taken in HEAD or DATA, including the tail beat.
  - Saturates at 2^LEN_W−1.
- On entry to TAIL: `pkt_len` is loaded with the final running length and `pkt_cnt` increments by 1.
- `head` and `tail` with `valid`=0 never cause a transition or an error.

## Timing
- All outputs are registered and reflect the inputs sampled at the preceding rising edge (latency 1 cycle). There are no combinational input-to-output paths.
- `sop`, `eop` and `err` are high for exactly one cycle per event.
- Asserting `reset` at any time, including mid-packet, immediately forces:
  - `state`=IDLE;
  - `busy`, `sop`, `eop`, `err` = 0;
  - `pkt_len`, `pkt_cnt` and the running length = 0.
- The first edge after `reset` deasserts is evaluated from IDLE.
- Simultaneous `head` and `tail` on one beat is a legal single-beat packet wherever a head is legal.

## Configuration
- Macro `FSM_ERR_CHECK_EN`.
- Defined: the error and restart behaviour above applies.
- Undefined:
  - `err` is tied to 0.
  - A head beat in HEAD or DATA is treated as an ordinary data beat (no restart).
  - A tail beat in IDLE, or in TAIL without head, is ignored.

## Test plan
- Reset held for 5 cycles, then released with all inputs at 0 → `state`=00; `busy`/`sop`/`eop`/`err`=0; `pkt_len`=0; `pkt_cnt`=0 throughout.
- Head beat, 3 data beats, tail beat, then `valid`=0 → state sequence 01,10,10,10,11,00; `sop` and `eop` one cycle each; `pkt_len`=5; `pkt_cnt`=1.
- Same packet with `valid`=0 for 2 cycles mid-DATA → state holds 10 during the stall; `pkt_len`=5.
- `head&tail&valid` on one beat from IDLE → TAIL next cycle; `sop`=0 and `eop`=1; `pkt_len`=1; then IDLE.
- With `FSM_ERR_CHECK_EN`: head beat, data beat, then head again → `err` pulses once; state 01 with `sop` pulsed; a subsequent tail gives `pkt_len`=2. Without the macro, the same stimulus gives `err`=0 and `pkt_len`=4.
- Reset asserted mid-DATA → state 00 and all outputs 0 immediately, without waiting for a clock edge.
